// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame sequencing controller.
// Provides the controller state encoding, the display mode encoding,
// the watchdog counter width and the saturating threshold step helper.
package frame_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_PAUSED
    } state_t;

    typedef enum logic [1:0] {
        MODE_GRAY  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_BIN   = 2'd2,
        MODE_SOBEL = 2'd3
    } mode_t;

    localparam int unsigned WD_W = 21;

    // Saturating +/- step; simultaneous up and down cancel out.
    function automatic logic [7:0] thr_next(input logic [7:0] cur,
                                            input logic [7:0] step,
                                            input logic       up,
                                            input logic       dn);
        logic [8:0] sum;
        sum      = {1'b0, cur} + {1'b0, step};
        thr_next = cur;
        if (up && !dn) begin
            thr_next = sum[8] ? 8'hFF : sum[7:0];
        end else if (dn && !up) begin
            thr_next = (cur < step) ? 8'h00 : cur - step;
        end
    endfunction

endpackage

// File: rtl/frame_seq_if.sv
// Control/status bundle between the frame controller and its environment.
// master: drives configuration status, key pulses and the capture stream
//         markers; observes capture enable, active mode/threshold, counters
//         and status flags.
// slave:  the controller side of the same signals.
interface frame_seq_if;
    logic        cfg_done;
    logic        key_mode;
    logic        key_up;
    logic        key_dn;
    logic        key_pause;
    logic        din_vld;
    logic        din_sop;
    logic        din_eop;
    logic        capture_en;
    logic [1:0]  mode;
    logic [7:0]  thr;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    logic        timeout;
    logic        busy;

    modport master (
        output cfg_done, key_mode, key_up, key_dn, key_pause,
               din_vld, din_sop, din_eop,
        input  capture_en, mode, thr, frame_cnt, err_cnt, timeout, busy
    );

    modport slave (
        input  cfg_done, key_mode, key_up, key_dn, key_pause,
               din_vld, din_sop, din_eop,
        output capture_en, mode, thr, frame_cnt, err_cnt, timeout, busy
    );
endinterface

// File: rtl/frame_watchdog.sv
// No-frame watchdog: counts cycles while run_i is high and no clear occurs.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   run_i      counting enabled (controller is capturing)
//   clr_i      restart the count (a frame start was seen)
//   expire_o   one-cycle pulse on the LIMIT-th uncleared running cycle
module frame_watchdog
    import frame_seq_pkg::*;
#(
    parameter int unsigned LIMIT = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [WD_W-1:0] cnt_q, cnt_d;

    assign expire_o = run_i && !clr_i && (cnt_q == WD_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run_i || clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame-level controller for the camera -> gray -> gauss -> binarise ->
// sobel -> VGA stream. Gates capture until sensor configuration is done,
// commits shadowed mode/threshold only at frame boundaries, supports
// pause/resume at frame end, counts frames and framing errors and runs a
// no-frame watchdog.
// Ports:
//   clk, rst   pixel clock, synchronous active-high reset
//   bus        frame_seq_if slave: cfg_done, key_* pulses, din_vld/sop/eop in;
//              capture_en, mode, thr, frame_cnt, err_cnt, timeout, busy out
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter logic [7:0]  THR_INIT = 8'd100,
    parameter logic [7:0]  THR_STEP = 8'd5,
    parameter int unsigned FRAME_TO = 2_000_000
) (
    input logic        clk,
    input logic        rst,
    frame_seq_if.slave bus
);

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d, mode_p_q, mode_p_d;
    logic [7:0]  thr_q, thr_d, thr_p_q, thr_p_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic        capture_en_q, capture_en_d;

    logic cap_act, sop, eop, frame_end, wd_run, wd_expire;

    // Stream markers only count while capture is live and configured.
    assign cap_act   = bus.cfg_done && (state_q inside {ST_ARM, ST_RUN, ST_DRAIN});
    assign sop       = cap_act && bus.din_vld && bus.din_sop;
    assign eop       = cap_act && bus.din_vld && bus.din_eop;
    // An eop closes a frame if one is open or opens in the same cycle.
    assign frame_end = eop && (busy_q || sop);
    assign wd_run    = state_q inside {ST_RUN, ST_DRAIN};

    frame_watchdog #(.LIMIT(FRAME_TO)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .run_i    (wd_run),
        .clr_i    (sop),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        timeout_d   = timeout_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        mode_d      = mode_q;
        thr_d       = thr_q;
        mode_p_d    = bus.key_mode ? mode_t'(mode_p_q + 2'd1) : mode_p_q;
        thr_p_d     = thr_next(thr_p_q, THR_STEP, bus.key_up, bus.key_dn);

        if (((sop && busy_q) || (eop && !busy_q && !sop)) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        if (sop) begin
            busy_d    = 1'b1;
            timeout_d = 1'b0;
        end
        if (frame_end) begin
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        // Commit uses the registered shadow, so a key pulse in this cycle
        // lands at the next boundary.
        if (frame_end || (state_q inside {ST_IDLE, ST_ARM, ST_PAUSED})) begin
            mode_d = mode_p_q;
            thr_d  = thr_p_q;
        end

        case (state_q)
            ST_IDLE: if (bus.cfg_done) state_d = ST_ARM;
            ST_ARM:  if (sop) state_d = ST_RUN;
            ST_RUN: begin
                if (wd_expire) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_ARM;
                end else if (bus.key_pause) begin
                    // Decided on post-cycle busy: a pause on the eop cycle
                    // needs no drain.
                    state_d = busy_d ? ST_DRAIN : ST_PAUSED;
                end
            end
            ST_DRAIN: begin
                if (wd_expire) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_PAUSED;
                end else if (frame_end) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: if (bus.key_pause) state_d = ST_ARM;
            default: state_d = ST_IDLE;
        endcase

        if (!bus.cfg_done) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end

        capture_en_d = state_d inside {ST_ARM, ST_RUN, ST_DRAIN};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
            mode_q       <= MODE_SOBEL;
            mode_p_q     <= MODE_SOBEL;
            thr_q        <= THR_INIT;
            thr_p_q      <= THR_INIT;
            capture_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            mode_q       <= mode_d;
            mode_p_q     <= mode_p_d;
            thr_q        <= thr_d;
            thr_p_q      <= thr_p_d;
            capture_en_q <= capture_en_d;
        end
    end

    assign bus.capture_en = capture_en_q;
    assign bus.mode       = mode_q;
    assign bus.thr        = thr_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.timeout    = timeout_q;
    assign bus.busy       = busy_q;

endmodule
